goofy_pattern_checker: RTL and testbench

Receive-side checker for the 4-phase "goofy counter" byte pattern 8'h81, 8'h42, 8'h24, 8'h18, which then repeats from 8'h81. It samples the byte stream on valid strobes, acquires lock, and tracks the pattern phase with a flywheel. It reports word errors and loses lock after repeated mismatches. It sits at the far end of any link carrying the generator output and serves as a link and bench integrity monitor.

---
 rtl/goofy_pkg.sv | 30 +++
 rtl/goofy_sat_counter.sv | 39 +++
 rtl/goofy_pattern_checker.sv | 146 ++++++++++++++
 tb/tb_goofy_pattern_checker.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/goofy_pkg.sv
// Shared definitions for the goofy counter pattern: word table, checker states,
// word decoder and the phase successor rule used by generator and checker alike.
package goofy_pkg;

    localparam logic [3:0][7:0] PATTERN = {8'h18, 8'h24, 8'h42, 8'h81};

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Returns {legal, index}; index is 0 when the byte is not a pattern word.
    function automatic logic [2:0] decode_word(input logic [7:0] word);
        logic [2:0] result;
        case (word)
            8'h81:   result = 3'b1_00;
            8'h42:   result = 3'b1_01;
            8'h24:   result = 3'b1_10;
            8'h18:   result = 3'b1_11;
            default: result = 3'b0_00;
        endcase
        return result;
    endfunction

    function automatic logic [1:0] next_phase(input logic [1:0] k);
        return k + 2'd1;
    endfunction

endpackage

// File: rtl/goofy_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes effect before the
// increment of the same cycle.
module goofy_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;
    logic [W-1:0] count_s;

    // Next count: clear first, then a saturating increment.
    always_comb begin
        count_s = count_r;
        if (clr) begin
            count_s = inc ? W'(1) : {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_s = count_r + W'(1);
        end else begin
            count_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else begin
            count_r <= count_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/goofy_pattern_checker.sv
// Receive-side checker for the 81/42/24/18 goofy counter stream: acquires lock,
// flywheels the expected phase and counts word errors while locked.
module goofy_pattern_checker
    import goofy_pkg::*;
#(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3,
    parameter int ERR_W        = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [7:0]       pattern_in,
    input  logic             pattern_valid,
    input  logic             clear_errors,
    output logic             locked,
    output logic [1:0]       phase,
    output logic             bit_error,
    output logic [ERR_W-1:0] error_count
);

    state_t     state_r,    state_s;
    logic [1:0] expected_r, expected_s;
    logic [3:0] good_r,     good_s;
    logic [3:0] bad_r,      bad_s;
    logic [1:0] phase_r,    phase_s;
    logic       locked_r;
    logic       bit_error_r, bit_error_s;

    logic [2:0] decode_s;
    logic       legal_s;
    logic [1:0] index_s;
    logic       match_s;
    logic       err_inc_s;

    assign decode_s = decode_word(pattern_in);
    assign legal_s  = decode_s[2];
    assign index_s  = decode_s[1:0];
    assign match_s  = (pattern_in == PATTERN[expected_r]);

    // Acquisition / flywheel next-state logic; only valid samples move state.
    always_comb begin
        state_s     = state_r;
        expected_s  = expected_r;
        good_s      = good_r;
        bad_s       = bad_r;
        phase_s     = phase_r;
        bit_error_s = 1'b0;
        err_inc_s   = 1'b0;
        if (pattern_valid) begin
            case (state_r)
                ST_SEARCH: begin
                    if (legal_s) begin
                        state_s    = ST_VERIFY;
                        expected_s = next_phase(index_s);
                        good_s     = 4'd1;
                        phase_s    = index_s;
                    end else begin
                        good_s     = 4'd0;
                    end
                end
                ST_VERIFY: begin
                    if (match_s) begin
                        good_s     = good_r + 4'd1;
                        expected_s = next_phase(expected_r);
                        phase_s    = expected_r;
                        if ((good_r + 4'd1) == 4'(LOCK_COUNT)) begin
                            state_s = ST_LOCKED;
                            bad_s   = 4'd0;
                        end else begin
                            state_s = ST_VERIFY;
                        end
                    end else if (legal_s) begin
                        // Legal but out of order: restart the in-sequence run here.
                        good_s     = 4'd1;
                        expected_s = next_phase(index_s);
                        phase_s    = index_s;
                    end else begin
                        state_s    = ST_SEARCH;
                        good_s     = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    expected_s = next_phase(expected_r);
                    phase_s    = expected_r;
                    if (match_s) begin
                        bad_s = 4'd0;
                    end else begin
                        bit_error_s = 1'b1;
                        err_inc_s   = 1'b1;
                        bad_s       = bad_r + 4'd1;
                        if ((bad_r + 4'd1) == 4'(UNLOCK_COUNT)) begin
                            state_s = ST_SEARCH;
                            good_s  = 4'd0;
                            bad_s   = 4'd0;
                        end else begin
                            state_s = ST_LOCKED;
                        end
                    end
                end
                default: begin
                    state_s = ST_SEARCH;
                    good_s  = 4'd0;
                    bad_s   = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_r     <= ST_SEARCH;
            expected_r  <= 2'd0;
            good_r      <= 4'd0;
            bad_r       <= 4'd0;
            phase_r     <= 2'd0;
            locked_r    <= 1'b0;
            bit_error_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            expected_r  <= expected_s;
            good_r      <= good_s;
            bad_r       <= bad_s;
            phase_r     <= phase_s;
            locked_r    <= (state_s == ST_LOCKED);
            bit_error_r <= bit_error_s;
        end
    end

    goofy_sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (clear_n),
        .clr   (clear_errors),
        .inc   (err_inc_s),
        .count (error_count)
    );

    assign locked    = locked_r;
    assign phase     = phase_r;
    assign bit_error = bit_error_r;

endmodule

// File: tb/tb_goofy_pattern_checker.sv
// Directed-vector bench: a default checker driven from a vector table, plus a
// narrow-counter instance for saturation, clear priority and async clear.
module tb_goofy_pattern_checker;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic [7:0] pattern_in = 8'h00;
    logic       pattern_valid = 1'b0;
    logic       clear_errors = 1'b0;

    logic       locked_a, bit_error_a;
    logic [1:0] phase_a;
    logic [7:0] error_count_a;
    logic       locked_b, bit_error_b;
    logic [1:0] phase_b;
    logic [1:0] error_count_b;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    goofy_pattern_checker dut_a (
        .clk           (clk),
        .clear_n       (clear_n),
        .pattern_in    (pattern_in),
        .pattern_valid (pattern_valid),
        .clear_errors  (clear_errors),
        .locked        (locked_a),
        .phase         (phase_a),
        .bit_error     (bit_error_a),
        .error_count   (error_count_a)
    );

    goofy_pattern_checker #(
        .LOCK_COUNT   (4),
        .UNLOCK_COUNT (15),
        .ERR_W        (2)
    ) dut_b (
        .clk           (clk),
        .clear_n       (clear_n),
        .pattern_in    (pattern_in),
        .pattern_valid (pattern_valid),
        .clear_errors  (clear_errors),
        .locked        (locked_b),
        .phase         (phase_b),
        .bit_error     (bit_error_b),
        .error_count   (error_count_b)
    );

    typedef struct {
        logic [7:0] pat;
        logic       vld;
        logic       clr;
        logic       exp_lock;
        logic [1:0] exp_ph;
        logic       chk_ph;
        logic       exp_be;
        int         exp_ec;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] pat, input logic vld, input logic clr,
                       input logic lk, input logic [1:0] ph, input logic chk_ph,
                       input logic be, input int ec);
        vec_t v;
        v.pat = pat; v.vld = vld; v.clr = clr; v.exp_lock = lk;
        v.exp_ph = ph; v.chk_ph = chk_ph; v.exp_be = be; v.exp_ec = ec;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] pat, input logic vld, input logic clr);
        @(negedge clk);
        pattern_in    = pat;
        pattern_valid = vld;
        clear_errors  = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // acquire: lock on the edge after the fourth in-sequence word
        add(8'h81,1'b1,1'b0, 1'b0,2'd0,1'b1, 1'b0,0);
        add(8'h42,1'b1,1'b0, 1'b0,2'd1,1'b1, 1'b0,0);
        add(8'h24,1'b1,1'b0, 1'b0,2'd2,1'b1, 1'b0,0);
        add(8'h18,1'b1,1'b0, 1'b1,2'd3,1'b1, 1'b0,0);
        add(8'h81,1'b1,1'b0, 1'b1,2'd0,1'b1, 1'b0,0);
        // single locked error, flywheel continues
        add(8'h42,1'b1,1'b0, 1'b1,2'd1,1'b1, 1'b0,0);
        add(8'hFF,1'b1,1'b0, 1'b1,2'd2,1'b1, 1'b1,1);
        add(8'h18,1'b1,1'b0, 1'b1,2'd3,1'b1, 1'b0,1);
        add(8'h00,1'b0,1'b0, 1'b1,2'd3,1'b1, 1'b0,1);
        add(8'h81,1'b1,1'b0, 1'b1,2'd0,1'b1, 1'b0,1);
        add(8'h00,1'b0,1'b1, 1'b1,2'd0,1'b1, 1'b0,0);
        // three consecutive errors drop lock on the third pulse
        add(8'h00,1'b1,1'b0, 1'b1,2'd1,1'b1, 1'b1,1);
        add(8'h00,1'b1,1'b0, 1'b1,2'd2,1'b1, 1'b1,2);
        add(8'h00,1'b1,1'b0, 1'b0,2'd3,1'b1, 1'b1,3);
        add(8'h81,1'b1,1'b0, 1'b0,2'd0,1'b1, 1'b0,3);
        // resync in VERIFY
        add(8'h42,1'b1,1'b0, 1'b0,2'd1,1'b1, 1'b0,3);
        add(8'h81,1'b1,1'b0, 1'b0,2'd0,1'b0, 1'b0,3);
        add(8'h42,1'b1,1'b0, 1'b0,2'd1,1'b1, 1'b0,3);
        add(8'h24,1'b1,1'b0, 1'b0,2'd2,1'b1, 1'b0,3);
        add(8'h18,1'b1,1'b0, 1'b1,2'd3,1'b1, 1'b0,3);
        // unlock again
        add(8'h00,1'b1,1'b0, 1'b1,2'd0,1'b1, 1'b1,4);
        add(8'h00,1'b1,1'b0, 1'b1,2'd1,1'b1, 1'b1,5);
        add(8'h00,1'b1,1'b0, 1'b0,2'd2,1'b1, 1'b1,6);
        // gaps during acquisition
        add(8'h81,1'b1,1'b0, 1'b0,2'd0,1'b1, 1'b0,6);
        for (int i = 0; i < 5; i++) add(8'hFF,1'b0,1'b0, 1'b0,2'd0,1'b1, 1'b0,6);
        add(8'h42,1'b1,1'b0, 1'b0,2'd1,1'b1, 1'b0,6);
        add(8'h24,1'b1,1'b0, 1'b0,2'd2,1'b1, 1'b0,6);
        add(8'h18,1'b1,1'b0, 1'b1,2'd3,1'b1, 1'b0,6);
        // unlock, then an illegal word in VERIFY returns to SEARCH
        add(8'h00,1'b1,1'b0, 1'b1,2'd0,1'b1, 1'b1,7);
        add(8'h00,1'b1,1'b0, 1'b1,2'd1,1'b1, 1'b1,8);
        add(8'h00,1'b1,1'b0, 1'b0,2'd2,1'b1, 1'b1,9);
        add(8'h81,1'b1,1'b0, 1'b0,2'd0,1'b1, 1'b0,9);
        add(8'h55,1'b1,1'b0, 1'b0,2'd0,1'b0, 1'b0,9);
        add(8'h42,1'b1,1'b0, 1'b0,2'd1,1'b1, 1'b0,9);
        add(8'h24,1'b1,1'b0, 1'b0,2'd2,1'b1, 1'b0,9);
        add(8'h18,1'b1,1'b0, 1'b0,2'd3,1'b1, 1'b0,9);
        add(8'h81,1'b1,1'b0, 1'b1,2'd0,1'b1, 1'b0,9);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_locked", int'(locked_a), 0);
        chk("reset_phase", int'(phase_a), 0);
        chk("reset_bit_error", int'(bit_error_a), 0);
        chk("reset_error_count", int'(error_count_a), 0);
        @(negedge clk);
        clear_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].pat, vecs[i].vld, vecs[i].clr);
            chk($sformatf("vec%0d_locked", i), int'(locked_a), int'(vecs[i].exp_lock));
            if (vecs[i].chk_ph) begin
                chk($sformatf("vec%0d_phase", i), int'(phase_a), int'(vecs[i].exp_ph));
            end else begin
                n_total = n_total;
            end
            chk($sformatf("vec%0d_bit_error", i), int'(bit_error_a), int'(vecs[i].exp_be));
            chk($sformatf("vec%0d_error_count", i), int'(error_count_a), vecs[i].exp_ec);
        end

        // restart both checkers for the saturation sequence
        @(negedge clk);
        clear_n = 1'b0;
        pattern_valid = 1'b0;
        clear_errors = 1'b0;
        #1;
        chk("rst2_locked_a", int'(locked_a), 0);
        chk("rst2_error_count_a", int'(error_count_a), 0);
        @(negedge clk);
        clear_n = 1'b1;
        step(8'h81, 1'b1, 1'b0);
        step(8'h42, 1'b1, 1'b0);
        step(8'h24, 1'b1, 1'b0);
        chk("sat_prelock", int'(locked_b), 0);
        step(8'h18, 1'b1, 1'b0);
        chk("sat_lock", int'(locked_b), 1);
        for (int i = 0; i < 5; i++) begin
            step(8'h00, 1'b1, 1'b0);
            chk($sformatf("sat_err%0d_count", i), int'(error_count_b), (i < 3) ? i + 1 : 3);
            chk($sformatf("sat_err%0d_pulse", i), int'(bit_error_b), 1);
            chk($sformatf("sat_err%0d_locked", i), int'(locked_b), 1);
        end
        step(8'h00, 1'b1, 1'b1);
        chk("clear_with_error_count", int'(error_count_b), 1);
        chk("clear_with_error_pulse", int'(bit_error_b), 1);
        chk("clear_with_error_phase", int'(phase_b), 1);
        step(8'h00, 1'b0, 1'b0);
        chk("idle_pulse_low", int'(bit_error_b), 0);

        // asynchronous clear between clock edges
        #2;
        clear_n = 1'b0;
        #1;
        chk("async_locked", int'(locked_b), 0);
        chk("async_phase", int'(phase_b), 0);
        chk("async_error_count", int'(error_count_b), 0);
        @(negedge clk);
        clear_n = 1'b1;
        step(8'h81, 1'b1, 1'b0);
        chk("post_async_no_lock", int'(locked_b), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
